// File: rtl/timer_irq_bank_pkg.sv
// Shared definitions for the timer interrupt bank: register map, CTRL bit
// positions and the per-channel state encoding.
package timer_irq_bank_pkg;

    localparam logic [1:0] REG_RELOAD   = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_COUNT    = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_STOP     = 2;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_IDLE = 2'd0;
    localparam chan_state_t ST_RUN  = 2'd1;
    localparam chan_state_t ST_FIRE = 2'd2;

    typedef struct packed {
        logic periodic;
        logic running;
    } chan_status_t;

endpackage

// File: rtl/timer_irq_bank_if.sv
// Single-cycle register bus between the CPU side and the timer bank.
interface timer_irq_bank_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/timer_irq_bank_channel.sv
// One countdown timer channel: RELOAD/PRESCALE registers, prescaler and the
// IDLE/RUN/FIRE sequencer producing a one-cycle irq pulse per expiry.
module timer_irq_channel
    import timer_irq_bank_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [1:0]       i_reg,
    input  logic [31:0]      i_wdata,
    output logic             o_irq,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_reload,
    output logic [PRE_W-1:0] o_prescale,
    output chan_status_t     o_status
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_count;
    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_curPre;
    logic             r_periodic;

    logic w_ctrlWr;
    logic w_start;
    logic w_stop;

    assign w_ctrlWr = i_we && (i_reg == REG_CTRL);
    assign w_stop   = w_ctrlWr && i_wdata[CTRL_STOP];
    assign w_start  = w_ctrlWr && i_wdata[CTRL_START] && (r_reload != '0);

    // STOP beats START, START beats normal counting. r_curPre is the prescale
    // latched at the last start/reload so live PRESCALE writes stay deferred.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_reload   <= '0;
            r_prescale <= '0;
            r_count    <= '0;
            r_pre      <= '0;
            r_curPre   <= '0;
            r_periodic <= 1'b0;
        end else begin
            if (i_we && (i_reg == REG_RELOAD))
                r_reload <= i_wdata[CNT_W-1:0];
            if (i_we && (i_reg == REG_PRESCALE))
                r_prescale <= i_wdata[PRE_W-1:0];

            if (w_stop) begin
                r_state <= ST_IDLE;
            end else if (w_start) begin
                r_state    <= ST_RUN;
                r_count    <= r_reload;
                r_pre      <= r_prescale;
                r_curPre   <= r_prescale;
                r_periodic <= i_wdata[CTRL_PERIODIC];
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if ((r_count == CNT_ONE) && (r_pre == '0)) begin
                            r_state <= ST_FIRE;
                            r_count <= '0;
                        end else if (r_pre != '0) begin
                            r_pre <= r_pre - PRE_ONE;
                        end else begin
                            r_pre   <= r_curPre;
                            r_count <= r_count - CNT_ONE;
                        end
                    end
                    ST_FIRE: begin
                        // The FIRE cycle is the first tick of the next period, so
                        // reload one step ahead; a 1-cycle period stretches to 2.
                        if (!r_periodic || (r_reload == '0)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state  <= ST_RUN;
                            r_curPre <= r_prescale;
                            if (r_prescale != '0) begin
                                r_count <= r_reload;
                                r_pre   <= r_prescale - PRE_ONE;
                            end else begin
                                r_count <= (r_reload == CNT_ONE) ? CNT_ONE : (r_reload - CNT_ONE);
                                r_pre   <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_irq           = (r_state == ST_FIRE);
    assign o_count         = r_count;
    assign o_reload        = r_reload;
    assign o_prescale      = r_prescale;
    assign o_status.running  = (r_state != ST_IDLE);
    assign o_status.periodic = r_periodic;

endmodule

// File: rtl/timer_irq_bank.sv
// Timer interrupt bank top: address decode, channel array and registered read mux.
// Defining TIMER_STATUS_LATCH_EN adds a sticky bank-wide STATUS register.
module timer_irq_bank
    import timer_irq_bank_pkg::*;
#(
    parameter int NUM_TIMERS = 3,
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_irq_bank_if.slave       bus,
    output logic [NUM_TIMERS-1:0] irq
);

    logic [3:0]            w_chan;
    logic [1:0]            w_reg;
    logic [NUM_TIMERS-1:0] w_chWe;
    logic [NUM_TIMERS-1:0] w_irq;
    logic [CNT_W-1:0]      w_count    [NUM_TIMERS];
    logic [CNT_W-1:0]      w_reload   [NUM_TIMERS];
    logic [PRE_W-1:0]      w_prescale [NUM_TIMERS];
    chan_status_t          w_status   [NUM_TIMERS];
    logic [31:0]           w_rdNext;
    logic [31:0]           r_rdata;

    assign w_chan = 4'(bus.addr >> 2);
    assign w_reg  = bus.addr[1:0];

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
        assign w_chWe[gi] = bus.we && (w_chan == 4'(gi));

        timer_irq_channel #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_we       (w_chWe[gi]),
            .i_reg      (w_reg),
            .i_wdata    (bus.wdata),
            .o_irq      (w_irq[gi]),
            .o_count    (w_count[gi]),
            .o_reload   (w_reload[gi]),
            .o_prescale (w_prescale[gi]),
            .o_status   (w_status[gi])
        );
    end

`ifdef TIMER_STATUS_LATCH_EN
    logic [NUM_TIMERS-1:0] r_status;
    logic                  w_statusWr;

    assign w_statusWr = bus.we && (w_chan == 4'(NUM_TIMERS)) && (w_reg == REG_RELOAD);

    // Write-one-to-clear; an expiry in the same cycle sets the bit again.
    always_ff @(posedge clk) begin
        if (!reset)
            r_status <= '0;
        else if (w_statusWr)
            r_status <= (r_status & ~bus.wdata[NUM_TIMERS-1:0]) | w_irq;
        else
            r_status <= r_status | w_irq;
    end
`endif

    always_comb begin
        w_rdNext = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (w_chan == 4'(i)) begin
                case (w_reg)
                    REG_RELOAD:   w_rdNext = 32'(w_reload[i]);
                    REG_PRESCALE: w_rdNext = 32'(w_prescale[i]);
                    REG_CTRL:     w_rdNext = {30'd0, w_status[i].periodic, w_status[i].running};
                    default:      w_rdNext = 32'(w_count[i]);
                endcase
            end
        end
`ifdef TIMER_STATUS_LATCH_EN
        if ((w_chan == 4'(NUM_TIMERS)) && (w_reg == REG_RELOAD))
            w_rdNext = 32'(r_status);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_rdata <= '0;
        else
            r_rdata <= w_rdNext;
    end

    assign bus.rdata = r_rdata;
    assign irq       = w_irq;

endmodule

// File: tb/tb_timer_irq_bank.sv
// Self-checking bench for timer_irq_bank: directed scenarios plus randomized
// register traffic checked against a cycle-number based expiry model.
module tb_timer_irq_bank;
    import timer_irq_bank_pkg::*;

    localparam int         NT          = 3;
    localparam logic [3:0] STATUS_ADDR = 4'd12;

    logic          clk    = 1'b0;
    logic          resetN = 1'b0;
    logic [NT-1:0] irq;

    timer_irq_bank_if #(.ADDR_W(4)) bus();

    timer_irq_bank #(
        .NUM_TIMERS (NT),
        .CNT_W      (32),
        .PRE_W      (16)
    ) dut (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Reference model: each running channel just remembers the absolute
    // cycle number of its next expiry.
    logic [31:0]   mReload   [NT];
    logic [15:0]   mPre      [NT];
    bit            mActive   [NT];
    bit            mPeriodic [NT];
    longint        mNext     [NT];
    logic [NT-1:0] expIrq;

    function automatic longint periodOf(input int ch);
        return (longint'(mPre[ch]) + 1) * longint'(mReload[ch]);
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < NT; i++) begin
            mReload[i]   = '0;
            mPre[i]      = '0;
            mActive[i]   = 1'b0;
            mPeriodic[i] = 1'b0;
            mNext[i]     = 0;
        end
        expIrq = '0;
    endfunction

    function automatic void modelEdge(input logic we, input logic [3:0] a, input logic [31:0] d);
        int     ch;
        longint p;
        ch     = int'(a[3:2]);
        expIrq = '0;
        if (we && ch < NT) begin
            case (a[1:0])
                2'd0: mReload[ch] = d;
                2'd1: mPre[ch]    = d[15:0];
                2'd2: begin
                    if (d[CTRL_STOP]) begin
                        mActive[ch] = 1'b0;
                    end else if (d[CTRL_START] && mReload[ch] != 0) begin
                        mActive[ch]   = 1'b1;
                        mPeriodic[ch] = d[CTRL_PERIODIC];
                        mNext[ch]     = cyc + periodOf(ch);
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < NT; i++) begin
            if (mActive[i] && mNext[i] == cyc) begin
                expIrq[i] = 1'b1;
                if (mPeriodic[i] && mReload[i] != 0) begin
                    p        = periodOf(i);
                    mNext[i] = cyc + ((p < 2) ? 2 : p);
                end else begin
                    mActive[i] = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [3:0] regAddr(input int ch, input int rg);
        return 4'(ch * 4 + rg);
    endfunction

    // One bus cycle: drive, let the edge capture it, then settle past the edge.
    task automatic applyStimulus(input logic we, input logic [3:0] a, input logic [31:0] d);
        bus.we    = we;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        cyc++;
        modelEdge(we, a, d);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic doReset();
        bus.we = 1'b0;
        resetN = 1'b0;
        @(posedge clk);
        cyc++;
        modelClear();
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (irq !== '0) begin
            errors++;
            $display("[TB] FAIL reset_irq got %b want 000", irq);
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h want 0", bus.rdata);
        end
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'(a), 32'h0);
            checks++;
            if (bus.rdata !== 32'h0 || irq !== '0) begin
                errors++;
                $display("[TB] FAIL reset_read addr=%0d got rdata=%h irq=%b want 0/000", a, bus.rdata, irq);
            end
        end
        applyStimulus(1'b1, regAddr(0, 3), 32'd5);
        applyStimulus(1'b0, regAddr(0, 3), 32'h0);
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL count_ro got %h want 0", bus.rdata);
        end
    endtask

    task automatic test_oneshot();
        int          pulses;
        logic [31:0] expCnt;
        pulses = 0;
        applyStimulus(1'b1, regAddr(0, 0), 32'd10);
        applyStimulus(1'b1, regAddr(0, 1), 32'd0);
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        for (int k = 1; k <= 110; k++) begin
            applyStimulus(1'b0, regAddr(0, 3), 32'h0);
            checks++;
            if (irq !== ((k == 10) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("[TB] FAIL oneshot_irq k=%0d got %b want %b", k, irq, (k == 10) ? 3'b001 : 3'b000);
            end
            if (irq[0]) pulses++;
            expCnt = (k - 1 >= 10) ? 32'd0 : 32'(10 - (k - 1));
            checks++;
            if (bus.rdata !== expCnt) begin
                errors++;
                $display("[TB] FAIL oneshot_count k=%0d got %0d want %0d", k, bus.rdata, expCnt);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL oneshot_pulses got %0d want 1", pulses);
        end
        applyStimulus(1'b0, regAddr(0, 2), 32'h0);
        checks++;
        if (bus.rdata[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_running got %b want 0", bus.rdata[0]);
        end
    endtask

    task automatic test_periodic();
        logic [2:0]  want;
        logic [31:0] expCnt;
        applyStimulus(1'b1, regAddr(1, 0), 32'd3);
        applyStimulus(1'b1, regAddr(1, 1), 32'd4);
        applyStimulus(1'b1, regAddr(1, 2), 32'h3);
        for (int k = 1; k <= 75; k++) begin
            if (k == 50) applyStimulus(1'b1, regAddr(1, 2), 32'h4);
            else         applyStimulus(1'b0, regAddr(1, 3), 32'h0);
            want = (k == 15 || k == 30 || k == 45) ? 3'b010 : 3'b000;
            checks++;
            if (irq !== want) begin
                errors++;
                $display("[TB] FAIL periodic_irq k=%0d got %b want %b", k, irq, want);
            end
            if (k <= 15) begin
                expCnt = 32'(3 - (k - 1) / 5);
                checks++;
                if (bus.rdata !== expCnt) begin
                    errors++;
                    $display("[TB] FAIL periodic_count k=%0d got %0d want %0d", k, bus.rdata, expCnt);
                end
            end
        end
        applyStimulus(1'b0, regAddr(1, 2), 32'h0);
        checks++;
        if (bus.rdata[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL periodic_running got %b want 0", bus.rdata[0]);
        end
        applyStimulus(1'b1, regAddr(1, 2), 32'h3);
        for (int k = 1; k <= 40; k++) begin
            if (k == 20) applyStimulus(1'b1, regAddr(1, 2), 32'h4);
            else         applyStimulus(1'b0, regAddr(1, 3), 32'h0);
            want = (k == 15) ? 3'b010 : 3'b000;
            checks++;
            if (irq !== want) begin
                errors++;
                $display("[TB] FAIL stop_irq k=%0d got %b want %b", k, irq, want);
            end
        end
    endtask

    task automatic test_period2();
        logic prev;
        prev = 1'b0;
        applyStimulus(1'b1, regAddr(2, 0), 32'd1);
        applyStimulus(1'b1, regAddr(2, 1), 32'd0);
        applyStimulus(1'b1, regAddr(2, 2), 32'h3);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, regAddr(2, 3), 32'h0);
            checks++;
            if (irq !== ((k % 2 == 1) ? 3'b100 : 3'b000)) begin
                errors++;
                $display("[TB] FAIL period2_irq k=%0d got %b want %b", k, irq, (k % 2 == 1) ? 3'b100 : 3'b000);
            end
            checks++;
            if (prev && irq[2]) begin
                errors++;
                $display("[TB] FAIL period2_gap k=%0d got 11 want a low cycle between pulses", k);
            end
            prev = irq[2];
        end
        applyStimulus(1'b1, regAddr(2, 2), 32'h4);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) applyStimulus(1'b0, regAddr(2, 2), 32'h0);
            checks++;
            if (irq !== 3'b000) begin
                errors++;
                $display("[TB] FAIL period2_stop k=%0d got %b want 000", k, irq);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] want;
        applyStimulus(1'b1, regAddr(1, 1), 32'd0);
        applyStimulus(1'b1, regAddr(0, 0), 32'd9);
        applyStimulus(1'b1, regAddr(1, 0), 32'd8);
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        applyStimulus(1'b1, regAddr(1, 2), 32'h1);
        for (int k = 2; k <= 20; k++) begin
            applyStimulus(1'b0, regAddr(0, 3), 32'h0);
            want = (k == 9) ? 3'b011 : 3'b000;
            checks++;
            if (irq !== want) begin
                errors++;
                $display("[TB] FAIL simul_irq k=%0d got %b want %b", k, irq, want);
            end
        end
    endtask

    task automatic test_start_ignored();
        applyStimulus(1'b1, regAddr(2, 0), 32'd0);
        applyStimulus(1'b1, regAddr(2, 2), 32'h1);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, regAddr(2, 2), 32'h0);
            checks++;
            if (irq !== 3'b000) begin
                errors++;
                $display("[TB] FAIL zero_reload_irq k=%0d got %b want 000", k, irq);
            end
        end
        checks++;
        if (bus.rdata[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_reload_running got %b want 0", bus.rdata[0]);
        end
        applyStimulus(1'b1, regAddr(2, 0), 32'd5);
        applyStimulus(1'b1, regAddr(2, 2), 32'h5);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, regAddr(2, 2), 32'h0);
            checks++;
            if (irq !== 3'b000) begin
                errors++;
                $display("[TB] FAIL startstop_irq k=%0d got %b want 000", k, irq);
            end
        end
        checks++;
        if (bus.rdata[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL startstop_running got %b want 0", bus.rdata[0]);
        end
    endtask

    task automatic test_restart();
        logic [2:0] want;
        applyStimulus(1'b1, regAddr(0, 0), 32'd6);
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) applyStimulus(1'b1, regAddr(0, 2), 32'h1);
            else        applyStimulus(1'b0, regAddr(0, 3), 32'h0);
            want = (k == 10) ? 3'b001 : 3'b000;
            checks++;
            if (irq !== want) begin
                errors++;
                $display("[TB] FAIL restart_irq k=%0d got %b want %b", k, irq, want);
            end
        end
    endtask

    task automatic test_reset_midcount();
        applyStimulus(1'b1, regAddr(0, 0), 32'd20);
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, regAddr(0, 3), 32'h0);
        doReset();
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, regAddr(0, 3), 32'h0);
            checks++;
            if (irq !== 3'b000 || bus.rdata !== 32'h0) begin
                errors++;
                $display("[TB] FAIL midreset k=%0d got irq=%b count=%0d want 000/0", k, irq, bus.rdata);
            end
        end
        applyStimulus(1'b0, regAddr(0, 0), 32'h0);
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_reload got %0d want 0", bus.rdata);
        end
        applyStimulus(1'b0, regAddr(0, 2), 32'h0);
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_ctrl got %h want 0", bus.rdata);
        end
    endtask

    task automatic test_status();
        applyStimulus(1'b1, regAddr(0, 0), 32'd4);
        applyStimulus(1'b1, regAddr(0, 1), 32'd0);
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, STATUS_ADDR, 32'h0);
        applyStimulus(1'b0, STATUS_ADDR, 32'h0);
`ifdef TIMER_STATUS_LATCH_EN
        checks++;
        if (bus.rdata !== 32'h1) begin
            errors++;
            $display("[TB] FAIL status_set got %h want 1", bus.rdata);
        end
        applyStimulus(1'b1, STATUS_ADDR, 32'h1);
        applyStimulus(1'b0, STATUS_ADDR, 32'h0);
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL status_clear got %h want 0", bus.rdata);
        end
        applyStimulus(1'b1, regAddr(0, 2), 32'h1);
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, STATUS_ADDR, 32'h0);
        checks++;
        if (irq !== 3'b001) begin
            errors++;
            $display("[TB] FAIL status_fire_align got %b want 001", irq);
        end
        applyStimulus(1'b1, STATUS_ADDR, 32'h1);
        applyStimulus(1'b0, STATUS_ADDR, 32'h0);
        checks++;
        if (bus.rdata !== 32'h1) begin
            errors++;
            $display("[TB] FAIL status_set_wins got %h want 1", bus.rdata);
        end
`else
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL status_absent got %h want 0", bus.rdata);
        end
`endif
    endtask

    task automatic test_random();
        int          r;
        int          ch;
        int          rg;
        logic [31:0] d;
        logic [31:0] want;
        doReset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                ch = $urandom_range(0, 2);
                rg = $urandom_range(0, 3);
                case (rg)
                    0:       d = 32'($urandom_range(0, 6));
                    1:       d = 32'($urandom_range(0, 3));
                    2:       d = {29'd0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 3) != 0)};
                    default: d = $urandom;
                endcase
                applyStimulus(1'b1, regAddr(ch, rg), d);
            end else if (r < 35) begin
                ch = $urandom_range(0, 3);
                rg = $urandom_range(0, 1);
                if (ch == 3) rg = rg + 1;
                applyStimulus(1'b0, regAddr(ch, rg), 32'h0);
                if (ch == 3)      want = 32'h0;
                else if (rg == 0) want = mReload[ch];
                else              want = 32'(mPre[ch]);
                checks++;
                if (bus.rdata !== want) begin
                    errors++;
                    $display("[TB] FAIL rand_read ch=%0d reg=%0d got %h want %h", ch, rg, bus.rdata, want);
                end
            end else begin
                applyStimulus(1'b0, 4'd0, 32'h0);
            end
            checks++;
            if (irq !== expIrq) begin
                errors++;
                $display("[TB] FAIL rand_irq n=%0d got %b want %b", n, irq, expIrq);
            end
        end
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        modelClear();
        test_reset();
        test_oneshot();
        test_periodic();
        test_period2();
        test_simultaneous();
        test_start_ignored();
        test_restart();
        test_reset_midcount();
        test_status();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
